// File: rtl/array_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : array_mem_responder
// Description : Registered RAM answering one kernel array port, with a
//               host side-port for preload/readback; cleared after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module array_mem_responder #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              k_wenable,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic [DATA_W-1:0] k_wdata,
    output logic [DATA_W-1:0] k_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_ack,
    output logic              ready
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [0:0]      c_ST_CLEAR = 1'b0;
    localparam logic [0:0]      c_ST_SERVE = 1'b1;
    localparam logic [ADDR_W-1:0] c_ONE    = 1;
    localparam logic [ADDR_W-1:0] c_LAST   = '1;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ready;
    logic              r_h_ack;
    logic [DATA_W-1:0] r_k_rdata;
    logic [DATA_W-1:0] r_h_rdata;

    logic              w_serve;
    logic              w_h_grant;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_serve = (r_state == c_ST_SERVE);

    // A pending ack blocks a new grant; host writes yield to kernel writes.
    assign w_h_grant = w_serve && h_req && !r_h_ack && (!h_we || !k_wenable);

    // Single write port: clear sweep, else kernel, else granted host write.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        if (!w_serve) begin
            w_mem_we = 1'b1;
        end else if (k_wenable) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = k_addr;
            w_mem_wdata = k_wdata;
        end else if (w_h_grant && h_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = h_addr;
            w_mem_wdata = h_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_CLEAR;
            r_ptr     <= '0;
            r_ready   <= 1'b0;
            r_h_ack   <= 1'b0;
            r_k_rdata <= '0;
            r_h_rdata <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_ptr <= r_ptr + c_ONE;
                    if (r_ptr == c_LAST) begin
                        r_state <= c_ST_SERVE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_k_rdata <= r_mem[k_addr];
                    r_h_ack   <= w_h_grant;
                    if (w_h_grant && !h_we) begin
                        r_h_rdata <= r_mem[h_addr];
                    end
                end
            endcase
        end
    end

    assign k_rdata = r_k_rdata;
    assign h_rdata = r_h_rdata;
    assign h_ack   = r_h_ack;
    assign ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_array_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_mem_responder
// Description : Directed and randomized bench against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_mem_responder;

    localparam int c_DATA_W = 64;
    localparam int c_ADDR_W = 1;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                k_wenable;
    logic [c_ADDR_W-1:0] k_addr;
    logic [c_DATA_W-1:0] k_wdata;
    logic [c_DATA_W-1:0] k_rdata;
    logic                h_req;
    logic                h_we;
    logic [c_ADDR_W-1:0] h_addr;
    logic [c_DATA_W-1:0] h_wdata;
    logic [c_DATA_W-1:0] h_rdata;
    logic                h_ack;
    logic                ready;

    array_mem_responder #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k_wenable (k_wenable),
        .k_addr    (k_addr),
        .k_wdata   (k_wdata),
        .k_rdata   (k_rdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_rdata   (h_rdata),
        .h_ack     (h_ack),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the array itself plus what each output should show.
    logic [c_DATA_W-1:0] m_mem [c_DEPTH];
    int                  m_cycles;
    logic [c_DATA_W-1:0] m_krd;
    logic [c_DATA_W-1:0] m_hrd;
    logic                m_ack;
    logic                m_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cycles = 0;
        m_krd    = '0;
        m_hrd    = '0;
        m_ack    = 1'b0;
        m_ready  = 1'b0;
    endtask

    // One rising edge: update the model from the inputs, check, return at negedge.
    task automatic step();
        logic [c_DATA_W-1:0] old_mem [c_DEPTH];
        bit                  grant;
        @(posedge clk);
        old_mem = m_mem;
        if (m_cycles < c_DEPTH) begin
            m_mem[m_cycles] = '0;
        end else begin
            m_krd = old_mem[k_addr];
            if (k_wenable) m_mem[k_addr] = k_wdata;
            grant = h_req && !m_ack && !(h_we && k_wenable);
            if (grant && h_we)  m_mem[h_addr] = h_wdata;
            if (grant && !h_we) m_hrd = old_mem[h_addr];
            m_ack = grant;
        end
        m_cycles++;
        m_ready = (m_cycles >= c_DEPTH);
        #1;
        chk("k_rdata", k_rdata, m_krd);
        chk("h_ack",   h_ack,   m_ack);
        chk("ready",   ready,   m_ready);
        chk("h_rdata", h_rdata, m_hrd);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        h_req     = 1'b0;
        k_wenable = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_h_ack", h_ack, 0);
        chk("rst_k_rdata", k_rdata, 0);
        chk("rst_h_rdata", h_rdata, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic host_op(input logic we, input logic [c_ADDR_W-1:0] a,
                           input logic [c_DATA_W-1:0] d, output logic [c_DATA_W-1:0] rd);
        bit acked = 0;
        k_wenable = 1'b0;
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        for (int i = 0; i < 10 && !acked; i++) begin
            step();
            if (h_ack) acked = 1;
        end
        chk("host_ack_seen", acked, 1);
        rd    = h_rdata;
        h_req = 1'b0;
    endtask

    logic [c_DATA_W-1:0] rd;
    int                  ack_at;

    initial begin
        rst_n = 1'b0; k_wenable = 0; k_addr = 0; k_wdata = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        model_reset();
        @(negedge clk);

        // T1: two-cycle clear sweep, then both words read as zero
        apply_reset();
        step(); chk("t1_ready_c1", ready, 0);
        step(); chk("t1_ready_c2", ready, 1);
        host_op(0, 0, 0, rd); chk("t1_rd0", rd, 0);
        host_op(0, 1, 0, rd); chk("t1_rd1", rd, 0);

        // T2: host preload -7, kernel reads it back one edge later
        host_op(1, 1, 64'hffff_ffff_ffff_fff9, rd);
        k_addr = 1; step(); chk("t2_k_rdata", k_rdata, 64'hffff_ffff_ffff_fff9);

        // T3: kernel write wins, host write lands one cycle later
        k_wenable = 1; k_addr = 0; k_wdata = 5;
        h_req = 1; h_we = 1; h_addr = 0; h_wdata = 9;
        step(); chk("t3_no_ack", h_ack, 0);
        k_wenable = 0;
        step(); chk("t3_ack_late", h_ack, 1); chk("t3_kread5", k_rdata, 5);
        h_req = 0;
        step(); chk("t3_final9", k_rdata, 9);

        // T4: read-first on same-cycle kernel read/write
        host_op(1, 1, 3, rd);
        k_wenable = 1; k_addr = 1; k_wdata = 4;
        step(); chk("t4_old3", k_rdata, 3);
        k_wenable = 0;
        step(); chk("t4_new4", k_rdata, 4);

        // T5: kernel write and host read during clear are ignored
        apply_reset();
        h_req = 1; h_we = 0; h_addr = 1;
        k_wenable = 1; k_addr = 0; k_wdata = 64'h77;
        k_addr = 1; step(); chk("t5_ack_c1", h_ack, 0);
        k_addr = 0; step(); chk("t5_ack_c2", h_ack, 0); chk("t5_ready", ready, 1);
        k_wenable = 0;
        step();
        chk("t5_ack_after_ready", h_ack, 1);
        chk("t5_hrd", h_rdata, 0);
        chk("t5_k0", k_rdata, 0);
        h_req = 0; k_addr = 1;
        step(); chk("t5_k1", k_rdata, 0);

        // T6: reset lands while a host read is presented
        h_req = 1; h_we = 0; h_addr = 0;
        #2 rst_n = 1'b0;
        #1 chk("t6_ready_async", ready, 0);
        chk("t6_ack_async", h_ack, 0);
        apply_reset();
        ack_at = 0;
        for (int i = 0; i < c_DEPTH; i++) begin
            step();
            if (h_ack) ack_at++;
        end
        chk("t6_no_ack", ack_at, 0);
        chk("t6_ready_again", ready, 1);

        // Randomized traffic with occasional mid-operation resets
        for (int n = 0; n < 400; n++) begin
            k_wenable = ($urandom_range(0, 2) == 0);
            k_addr    = c_ADDR_W'($urandom_range(0, c_DEPTH - 1));
            k_wdata   = {$urandom(), $urandom()};
            if (h_req && h_ack) begin
                h_req = 0;
            end else if (!h_req && $urandom_range(0, 1) == 1) begin
                h_req   = 1;
                h_we    = $urandom_range(0, 1) == 1;
                h_addr  = c_ADDR_W'($urandom_range(0, c_DEPTH - 1));
                h_wdata = {$urandom(), $urandom()};
            end
            if ($urandom_range(0, 99) == 0) begin
                #2 apply_reset();
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
